// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: passes non-memory ops through to MEM/WB and
// runs a request/ack bus transaction for loads and stores, stalling the
// pipeline until the transaction completes. Big-endian byte lanes.
module mem_access_unit (
    input  logic        clock,
    input  logic        reset,
    // EX/MEM fields
    input  logic [4:0]  write_reg_address_input,
    input  logic        write_reg_enable_input,
    input  logic [31:0] write_reg_data_input,
    input  logic [31:0] hi_input,
    input  logic [31:0] lo_input,
    input  logic        whilo_input,
    input  logic [7:0]  aluop_input,
    input  logic [31:0] memory_address_input,
    input  logic [31:0] reg2_input,
    // MEM/WB fields
    output logic [4:0]  write_reg_address_output,
    output logic        write_reg_enable_output,
    output logic [31:0] write_reg_data_output,
    output logic [31:0] hi_output,
    output logic [31:0] lo_output,
    output logic        whilo_output,
    output logic        stall_request,
    // data bus
    output logic        bus_request,
    output logic        bus_write_enable,
    output logic [31:0] bus_address,
    output logic [3:0]  bus_select,
    output logic [31:0] bus_write_data,
    input  logic [31:0] bus_read_data,
    input  logic        bus_ack
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, DONE} state_t;

    state_t      state, next_state;
    logic        is_load, is_store, is_mem;
    logic [3:0]  sel_c;
    logic [31:0] wdata_c;
    logic [31:0] load_buf;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    // Decode the operation class.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        case (aluop_input)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: is_load  = 1'b1;
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP:                         is_store = 1'b1;
            default: ;
        endcase
        is_mem = is_load | is_store;
    end

    // Byte enables and replicated store data; word ops ignore address[1:0].
    always_comb begin
        sel_c   = 4'b1111;
        wdata_c = 32'h0;
        case (aluop_input)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: sel_c = 4'b1000 >> memory_address_input[1:0];
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: sel_c = memory_address_input[1] ? 4'b0011 : 4'b1100;
            default: ;
        endcase
        case (aluop_input)
            EXE_SB_OP: wdata_c = {4{reg2_input[7:0]}};
            EXE_SH_OP: wdata_c = {2{reg2_input[15:0]}};
            EXE_SW_OP: wdata_c = reg2_input;
            default: ;
        endcase
    end

    // Lane extraction and sign/zero extension of the captured load word.
    always_comb begin
        case (memory_address_input[1:0])
            2'b00:   ld_byte = load_buf[31:24];
            2'b01:   ld_byte = load_buf[23:16];
            2'b10:   ld_byte = load_buf[15:8];
            default: ld_byte = load_buf[7:0];
        endcase
        ld_half = memory_address_input[1] ? load_buf[15:0] : load_buf[31:16];
        case (aluop_input)
            EXE_LB_OP:  load_data = {{24{ld_byte[7]}}, ld_byte};
            EXE_LBU_OP: load_data = {24'h0, ld_byte};
            EXE_LH_OP:  load_data = {{16{ld_half[15]}}, ld_half};
            EXE_LHU_OP: load_data = {16'h0, ld_half};
            default:    load_data = load_buf;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic: launch on a memory op, wait for ack, one DONE cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (is_mem)  next_state = WAIT_ACK;
            WAIT_ACK: if (bus_ack) next_state = DONE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Bus strobe/fields are registered at launch and held until ack;
    // ack in IDLE or DONE is ignored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_request      <= 1'b0;
            bus_write_enable <= 1'b0;
            bus_address      <= 32'h0;
            bus_select       <= 4'b0000;
            bus_write_data   <= 32'h0;
            load_buf         <= 32'h0;
        end else begin
            case (state)
                IDLE: if (is_mem) begin
                    bus_request      <= 1'b1;
                    bus_write_enable <= is_store;
                    bus_address      <= {memory_address_input[31:2], 2'b00};
                    bus_select       <= sel_c;
                    bus_write_data   <= wdata_c;
                end
                WAIT_ACK: if (bus_ack) begin
                    load_buf    <= bus_read_data;
                    bus_request <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // MEM/WB outputs: pass-through, with load result substituted in DONE.
    // Everything reads zero while reset is held.
    always_comb begin
        write_reg_address_output = 5'h0;
        write_reg_enable_output  = 1'b0;
        write_reg_data_output    = 32'h0;
        hi_output                = 32'h0;
        lo_output                = 32'h0;
        whilo_output             = 1'b0;
        stall_request            = 1'b0;
        if (reset) begin
            write_reg_address_output = write_reg_address_input;
            write_reg_enable_output  = write_reg_enable_input;
            write_reg_data_output    = write_reg_data_input;
            hi_output                = hi_input;
            lo_output                = lo_input;
            whilo_output             = whilo_input;
            stall_request            = (state == WAIT_ACK) || (state == IDLE && is_mem);
            if (state == DONE && is_load)
                write_reg_data_output = load_data;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: pass-through, load/store lane rules,
// stall length vs ack delay, back-to-back ops, spurious ack, reset mid-op.
module tb_mem_access_unit;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    logic        clock, reset;
    logic [4:0]  wa_i;
    logic        we_i;
    logic [31:0] wd_i, hi_i, lo_i;
    logic        whilo_i;
    logic [7:0]  aluop;
    logic [31:0] addr, reg2;
    logic [4:0]  wa_o;
    logic        we_o;
    logic [31:0] wd_o, hi_o, lo_o;
    logic        whilo_o, stall;
    logic        breq, bwe;
    logic [31:0] baddr, bwdata, brdata;
    logic [3:0]  bsel;
    logic        back;

    int n_pass = 0;
    int n_total = 0;

    mem_access_unit dut (
        .clock(clock), .reset(reset),
        .write_reg_address_input(wa_i), .write_reg_enable_input(we_i),
        .write_reg_data_input(wd_i), .hi_input(hi_i), .lo_input(lo_i),
        .whilo_input(whilo_i), .aluop_input(aluop),
        .memory_address_input(addr), .reg2_input(reg2),
        .write_reg_address_output(wa_o), .write_reg_enable_output(we_o),
        .write_reg_data_output(wd_o), .hi_output(hi_o), .lo_output(lo_o),
        .whilo_output(whilo_o), .stall_request(stall),
        .bus_request(breq), .bus_write_enable(bwe), .bus_address(baddr),
        .bus_select(bsel), .bus_write_data(bwdata),
        .bus_read_data(brdata), .bus_ack(back)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drives a memory op at the current negedge, acks in cycle N+k, checks the
    // held bus fields every wait cycle and the result in DONE.
    task automatic run_mem(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] r2, input logic [31:0] rdata, input int k,
                           input logic exp_we, input logic [3:0] exp_sel,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_res);
        int stalls;
        aluop = op; addr = a; reg2 = r2; brdata = rdata;
        #1;
        stalls = stall ? 1 : 0;
        for (int i = 1; i <= k; i++) begin
            @(negedge clock);
            if (stall) stalls++;
            chk({tag, " req"}, {31'h0, breq}, 32'h1);
            chk({tag, " we"},  {31'h0, bwe}, {31'h0, exp_we});
            chk({tag, " addr"}, baddr, {a[31:2], 2'b00});
            chk({tag, " sel"}, {28'h0, bsel}, {28'h0, exp_sel});
            if (exp_we) chk({tag, " wdata"}, bwdata, exp_wdata);
            if (i == k) back = 1'b1;
        end
        @(negedge clock);
        back = 1'b0;
        brdata = 32'h5A5A_5A5A;
        chk({tag, " done stall"}, {31'h0, stall}, 32'h0);
        chk({tag, " done req"}, {31'h0, breq}, 32'h0);
        chk({tag, " result"}, wd_o, exp_res);
        chk({tag, " wb addr"}, {27'h0, wa_o}, {27'h0, wa_i});
        chk({tag, " stall cycles"}, stalls, k + 1);
    endtask

    initial begin
        reset = 1'b0;
        wa_i = 5'd5; we_i = 1'b1; wd_i = 32'h1234;
        hi_i = 32'hAAAA_0001; lo_i = 32'hBBBB_0002; whilo_i = 1'b1;
        aluop = OP_LW; addr = 32'h100; reg2 = 32'h0;
        brdata = 32'h0; back = 1'b0;

        // Reset state, with a memory op presented on the inputs.
        #12;
        chk("rst stall", {31'h0, stall}, 32'h0);
        chk("rst req", {31'h0, breq}, 32'h0);
        chk("rst sel", {28'h0, bsel}, 32'h0);
        chk("rst wdata out", wd_o, 32'h0);
        chk("rst hi out", hi_o, 32'h0);
        aluop = OP_NOP;
        @(negedge clock);
        reset = 1'b1;

        // ALU op: pure pass-through, no stall, no bus activity.
        @(negedge clock);
        chk("alu wa", {27'h0, wa_o}, 32'd5);
        chk("alu we", {31'h0, we_o}, 32'h1);
        chk("alu wd", wd_o, 32'h1234);
        chk("alu hi", hi_o, 32'hAAAA_0001);
        chk("alu lo", lo_o, 32'hBBBB_0002);
        chk("alu whilo", {31'h0, whilo_o}, 32'h1);
        chk("alu stall", {31'h0, stall}, 32'h0);
        @(negedge clock);
        chk("alu req", {31'h0, breq}, 32'h0);

        wa_i = 5'd9; wd_i = 32'h0000_0055;
        @(negedge clock);
        run_mem("lb",  OP_LB,  32'h101, 32'h0, 32'h11F2_3344, 1, 1'b0, 4'b0100, 32'h0, 32'hFFFF_FFF2);
        chk("lb hi", hi_o, 32'hAAAA_0001);
        @(negedge clock);
        run_mem("lhu", OP_LHU, 32'h102, 32'h0, 32'hAAAA_8001, 1, 1'b0, 4'b0011, 32'h0, 32'h0000_8001);
        @(negedge clock);
        run_mem("lhu3", OP_LHU, 32'h102, 32'h0, 32'hAAAA_8001, 3, 1'b0, 4'b0011, 32'h0, 32'h0000_8001);
        @(negedge clock);
        run_mem("lh",  OP_LH,  32'h101, 32'h0, 32'h8001_AAAA, 2, 1'b0, 4'b1100, 32'h0, 32'hFFFF_8001);
        @(negedge clock);
        run_mem("lbu", OP_LBU, 32'h103, 32'h0, 32'h0000_00F0, 1, 1'b0, 4'b0001, 32'h0, 32'h0000_00F0);
        @(negedge clock);
        run_mem("sb",  OP_SB,  32'h203, 32'h0000_00AB, 32'h0, 1, 1'b1, 4'b0001, 32'hABAB_ABAB, 32'h0000_0055);
        @(negedge clock);
        run_mem("sh",  OP_SH,  32'h202, 32'h1234_CDEF, 32'h0, 1, 1'b1, 4'b0011, 32'hCDEF_CDEF, 32'h0000_0055);
        @(negedge clock);
        run_mem("sw",  OP_SW,  32'h203, 32'hDEAD_BEEF, 32'h0, 2, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0055);

        // Back-to-back loads: second op enters IDLE the cycle after DONE.
        @(negedge clock);
        run_mem("lw1", OP_LW, 32'h010, 32'h0, 32'hCAFE_F00D, 1, 1'b0, 4'b1111, 32'h0, 32'hCAFE_F00D);
        @(negedge clock);
        run_mem("lw2", OP_LW, 32'h016, 32'h0, 32'h0102_0304, 1, 1'b0, 4'b1111, 32'h0, 32'h0102_0304);

        // Spurious ack in IDLE with a non-memory op.
        @(negedge clock);
        aluop = OP_NOP; back = 1'b1; brdata = 32'hFFFF_FFFF;
        @(negedge clock);
        back = 1'b0;
        chk("spur req", {31'h0, breq}, 32'h0);
        chk("spur stall", {31'h0, stall}, 32'h0);
        chk("spur wd", wd_o, 32'h0000_0055);

        // Reset while waiting for ack; the pending op restarts afterwards.
        @(negedge clock);
        aluop = OP_LW; addr = 32'h040;
        @(negedge clock);
        chk("mid req before", {31'h0, breq}, 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("mid req async", {31'h0, breq}, 32'h0);
        chk("mid stall", {31'h0, stall}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        run_mem("restart", OP_LW, 32'h040, 32'h0, 32'h7777_8888, 1, 1'b0, 4'b1111, 32'h0, 32'h7777_8888);

        @(negedge clock);
        aluop = OP_NOP;
        @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety net so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
